// File: rtl/serial_bit_source_if.sv
// Handshake and serial-output bundle for serial_bit_source.
// The slave side is the serializer; the master side is the word producer / line observer.
interface serial_bit_source_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;

    modport master (
        output load_data, load_valid,
        input  load_ready, sout, sout_valid, busy
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, sout, sout_valid, busy
    );
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and emits
// one bit per clock, reloading on the last bit so consecutive words run gap-free.
module serial_bit_source #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    serial_bit_source_if.slave  bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic last_bit;
    logic load_ready;
    logic xfer;
    logic sout;
    logic sout_valid;
    logic busy;

    assign last_bit   = (cnt_q == LAST);
    // Ready in the last bit cycle lets the next word load at the same edge.
    assign load_ready = !rst && ((state_q == IDLE) || last_bit);
    assign xfer       = bus.load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = SHIFT;
            SHIFT:   if (last_bit && !xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            shreg_d = bus.load_data;
            cnt_d   = '0;
        end else if (state_q == SHIFT && !last_bit) begin
            if (MSB_FIRST)
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            else
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
        end else if (state_q == SHIFT) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        sout       = IDLE_LEVEL;
        sout_valid = 1'b0;
        busy       = 1'b0;
        if (state_q == SHIFT) begin
            sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            sout_valid = 1'b1;
            busy       = 1'b1;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.sout       = sout;
    assign bus.sout_valid = sout_valid;
    assign bus.busy       = busy;
endmodule
